// File: rtl/dram_port_ctrl.sv
// dram_port_ctrl: one-outstanding-request controller for a 16-bit DRAM port slice.
// Define DRAM_BOUNDS_CHECK_EN to reject addresses >= MEM_DEPTH with resp_err.
module dram_port_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int READ_LAT  = 1,
  parameter int MEM_DEPTH = 1025
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] DEPTH = AW1'(MEM_DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_t state, state_nxt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        cnt;
  logic              oob;

`ifdef DRAM_BOUNDS_CHECK_EN
  assign oob = ({1'b0, req_addr} >= DEPTH);
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH;
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req_valid) state_nxt = oob ? RESP : ISSUE;
      ISSUE: state_nxt = lat_we ? RESP : WAIT;
      WAIT:  if (cnt == 3'd0) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE:  req_ready  = !rst;
      ISSUE: mem_we     = lat_we;
      RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Rejected requests leave the latches alone so the held DRAM port stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          resp_err <= oob;
          if (oob) begin
            resp_rdata <= '0;
          end else begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
          end
        end
        ISSUE: begin
          if (lat_we) resp_rdata <= '0;
          else        cnt        <= CNT_INIT;
        end
        WAIT: begin
          if (cnt == 3'd0) resp_rdata <= mem_rdata;
          else             cnt        <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: doc/dram_port_ctrl.md
Name: dram_port_ctrl

Overview:
Per-core memory access controller sitting directly upstream of one 16-bit DRAM port slice.
- Accepts a single read or write request from a core over a valid/ready handshake.
- Drives the DRAM port's write enable, address and write data for exactly one cycle, then waits out the DRAM's registered read latency.
- Returns the result over a valid/ready response handshake.
- The top level instantiates `NUM_C+1` copies; copy i connects to DRAM slice `[i*16 +: 16]` and to bit i of `write_en`.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: address width.
- READ_LAT, 1: cycles from the DRAM sampling an address to `mem_rdata` being valid. Legal range is 1..7.
- MEM_DEPTH, 1025: number of implemented DRAM words. Used only when the bounds-check feature is enabled.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- resp_err  out  1  address error; constant 0 when the feature is off.
- mem_we  out  1  to DRAM `write_en[i]`.
- mem_addr  out  ADDR_W  to DRAM `addr` slice.
- mem_wdata  out  DATA_W  to DRAM `data_in` slice.
- mem_rdata  in  DATA_W  from DRAM `data_out` slice.

Behaviour:
- Reset: applied asynchronously. While `rst`=1 and immediately after release, all of the following are 0: `mem_we`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_rdata`, `resp_err`, and the internal latches and wait counter. The FSM is forced to IDLE. `req_ready`=0 while `rst`=1.
- FSM states: IDLE, ISSUE, WAIT, RESP. `req_ready`=1 only in IDLE.
- IDLE: on an edge with `req_valid`=1, latch `req_we`, `req_addr` and `req_wdata`, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive `mem_addr` and `mem_wdata` from the latches.
  - `mem_we` = latched we; it is 1 only in this state.
  - Write: next state RESP, `resp_rdata` <= 0.
  - Read: load the counter with READ_LAT-1, next state WAIT.
- WAIT:
  - `mem_addr` is held stable.
  - If counter==0: `resp_rdata` <= `mem_rdata`, go to RESP.
  - Else: decrement the counter.
- RESP: `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until an edge with `resp_ready`=1, which returns the FSM to IDLE. `resp_ready` is ignored in all other states.
- Latency, with accept edge E0:
  - Write: `resp_valid` is high after E0+1.
  - Read: `resp_valid` is high after E0+1+READ_LAT.
  - Minimum request-to-request spacing is 3 cycles for a write and 3+READ_LAT cycles for a read, given immediate `resp_ready`.
- Hold outputs: `mem_addr` and `mem_wdata` keep their last values outside ISSUE. The DRAM performs harmless reads at the held address.
- Outstanding requests: at most one. Back-to-back requests stall via `req_ready`=0; there is no queuing.
- Reset mid-operation: from any state, the FSM returns to IDLE and the response is dropped. If reset occurs during ISSUE, `mem_we` falls asynchronously, so no DRAM write is performed at the next edge.
- Widths: `mem_addr` is passed through unmodified; no wrap or truncation is applied here.

Optional Feature:
Macro DRAM_BOUNDS_CHECK_EN.
- Defined: in IDLE on accept, if `req_addr` >= MEM_DEPTH:
  - Skip ISSUE and WAIT; next state is RESP with `resp_err`=1 and `resp_rdata`=0.
  - `mem_we` is never asserted for that request.
  - In-range requests set `resp_err`=0.
- Undefined: `resp_err` is tied 0 and all addresses are forwarded unchecked.

Test Plan:
1. Reset then read: DRAM preloaded `ram[3]`=23, READ_LAT=1; request read `addr`=3 accepted at E0 -> `resp_valid`=1 after E0+2, `resp_rdata`=16'd23, `mem_we` never 1.
2. Write then read: write `addr`=10, `data`=16'hBEEF -> `mem_we`=1 for exactly one cycle with `mem_addr`=10, `resp_valid` after E0+1 with `resp_rdata`=0; a following read of `addr`=10 returns 16'hBEEF.
3. Backpressure: hold `resp_ready`=0 for 5 cycles after a read of `addr`=7 (preloaded 2199) -> `resp_valid` and `resp_rdata`=2199 stay stable, `req_ready`=0, and a concurrent `req_valid` is not accepted until after the `resp_ready` edge.
4. Latency parameter: READ_LAT=3, read `addr`=2 (preloaded 3) -> `resp_valid` after E0+4 with `resp_rdata`=3.
5. Reset mid-op: assert `rst` during WAIT, and separately during ISSUE of a write to `addr`=20 -> all outputs 0 immediately, `ram[20]` unchanged, no response after release.
6. Bounds: with DRAM_BOUNDS_CHECK_EN, read `addr`=2000 -> `resp_err`=1 and `resp_rdata`=0 after E0+1, no `mem_we`; without the macro -> `mem_addr`=2000 is issued and `resp_err`=0.
